// File: rtl/rng_uart_pkg.sv
// Shared types and constants for the entropy-to-UART byte stream.
// Holds the TX frame state encoding, 8N1/8E1 framing levels and the default baud divider.
package rng_uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  localparam logic        START_BIT        = 1'b0;
  localparam logic        STOP_BIT         = 1'b1;
  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned DEFAULT_BAUD_DIV = 868;

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input uart_byte_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/rng_uart_tx.sv
// UART byte serialiser: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Accepts a byte over valid/ready only while idle; every non-idle state lasts BAUD_DIV cycles.
module rng_uart_tx
  import rng_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  uart_byte_t byte_data,
  input  logic       byte_valid,
  output logic       byte_ready_c,
  output logic       active_c,
  output logic       tx
);

  localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  tx_state_t         state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_idx;
  uart_byte_t        shreg;
  logic              parity;
  logic              baud_done_c;

  assign byte_ready_c = (state == TX_IDLE);
  assign active_c     = (state != TX_IDLE);
  assign baud_done_c  = (baud_cnt == '0);

  // Frame FSM; tx is updated together with the state so the line level is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      parity   <= 1'b0;
      tx       <= STOP_BIT;
    end else begin
      case (state)
        TX_IDLE: begin
          tx <= STOP_BIT;
          if (byte_valid) begin
            shreg    <= byte_data;
            parity   <= even_parity(byte_data);
            baud_cnt <= BAUD_LAST;
            bit_idx  <= '0;
            state    <= TX_START;
            tx       <= START_BIT;
          end
        end

        TX_START: begin
          if (baud_done_c) begin
            baud_cnt <= BAUD_LAST;
            bit_idx  <= '0;
            state    <= TX_DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        TX_DATA: begin
          if (baud_done_c) begin
            baud_cnt <= BAUD_LAST;
            if (bit_idx == BIT_LAST) begin
              if (PARITY_EN) begin
                state <= TX_PARITY;
                tx    <= parity;
              end else begin
                state <= TX_STOP;
                tx    <= STOP_BIT;
              end
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        TX_PARITY: begin
          if (baud_done_c) begin
            baud_cnt <= BAUD_LAST;
            state    <= TX_STOP;
            tx       <= STOP_BIT;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        TX_STOP: begin
          if (baud_done_c) begin
            state <= TX_IDLE;
            tx    <= STOP_BIT;
          end else begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
          end
        end

        default: begin
          state <= TX_IDLE;
          tx    <= STOP_BIT;
        end
      endcase
    end
  end

endmodule

// File: rtl/rng_uart_stream.sv
// Entropy combiner, optional von Neumann debias, byte packer, byte FIFO and UART output.
// Emits either a continuous byte stream or one WORD_BYTES word per button rising edge.
module rng_uart_stream
  import rng_uart_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter bit          DEBIAS     = 1'b1,
  parameter bit          PARITY_EN  = 1'b0
) (
  input  logic              sys_Clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] entropy_Bits,
  input  logic              entropy_Valid,
  input  logic              button,
  input  logic              mode,
  output logic              tx,
  output logic              busy,
  output logic              fifo_Overflow
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned REQ_W = $clog2(WORD_BYTES + 1);
  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  logic             raw_bit_c;
  logic             pair_full;
  logic             pair_first;
  logic             acc_en_c;
  logic             acc_bit_c;
  uart_byte_t       acc;
  uart_byte_t       acc_next_c;
  logic [CNT_W-1:0] bit_cnt;
  logic             byte_done;
  uart_byte_t       byte_q;

  logic             button_q;
  logic [REQ_W-1:0] req_cnt;
  logic             req_start_c;
  logic             push_c;

  uart_byte_t       mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty_c;
  logic             fifo_full_c;
  logic             pop_c;
  logic             wr_en_c;

  logic             tx_ready_c;
  logic             tx_active_c;
  uart_byte_t       tx_data_c;

  assign raw_bit_c = ^entropy_Bits;

  // Accepted-bit selection: raw bits pass through, or only the first bit of a 01/10 pair.
  always_comb begin
    acc_en_c  = 1'b0;
    acc_bit_c = raw_bit_c;
    if (entropy_Valid) begin
      if (!DEBIAS) begin
        acc_en_c = 1'b1;
      end else if (pair_full && (pair_first != raw_bit_c)) begin
        acc_en_c  = 1'b1;
        acc_bit_c = pair_first;
      end
    end
  end

  assign acc_next_c  = {acc[DATA_BITS-2:0], acc_bit_c};
  assign req_start_c = button & ~button_q & ~mode & (req_cnt == '0);
  assign push_c      = byte_done & (mode | (req_cnt != '0));

  // Debias pair register and byte accumulator; a new request restarts both from fresh bits.
  always_ff @(posedge sys_Clk) begin
    if (reset) begin
      pair_full  <= 1'b0;
      pair_first <= 1'b0;
      acc        <= '0;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      byte_q     <= '0;
      button_q   <= 1'b0;
    end else begin
      button_q  <= button;
      byte_done <= 1'b0;
      if (req_start_c) begin
        pair_full <= 1'b0;
        acc       <= '0;
        bit_cnt   <= '0;
      end else begin
        if (DEBIAS && entropy_Valid) begin
          pair_full <= ~pair_full;
          if (!pair_full) begin
            pair_first <= raw_bit_c;
          end
        end
        if (acc_en_c) begin
          acc <= acc_next_c;
          if (bit_cnt == CNT_LAST) begin
            bit_cnt   <= '0;
            byte_done <= 1'b1;
            byte_q    <= acc_next_c;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // Outstanding single-shot byte budget; continuous mode holds it at zero.
  always_ff @(posedge sys_Clk) begin
    if (reset) begin
      req_cnt <= '0;
    end else if (mode) begin
      req_cnt <= '0;
    end else if (req_start_c) begin
      req_cnt <= REQ_W'(WORD_BYTES);
    end else if (push_c) begin
      req_cnt <= req_cnt - REQ_W'(1);
    end
  end

  assign fifo_empty_c = (wr_ptr == rd_ptr);
  assign fifo_full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_c        = tx_ready_c & ~fifo_empty_c;
  assign wr_en_c      = push_c & (~fifo_full_c | pop_c);
  assign tx_data_c    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_Clk) begin
    if (wr_en_c) begin
      mem[wr_ptr[AW-1:0]] <= byte_q;
    end
  end

  // FIFO pointers; a push into a full FIFO survives only if the head is popped that cycle.
  always_ff @(posedge sys_Clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_Overflow <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (push_c && fifo_full_c && !pop_c) begin
        fifo_Overflow <= 1'b1;
      end
    end
  end

  rng_uart_tx #(
    .BAUD_DIV  (BAUD_DIV),
    .PARITY_EN (PARITY_EN)
  ) u_tx (
    .clk          (sys_Clk),
    .rst          (reset),
    .byte_data    (tx_data_c),
    .byte_valid   (~fifo_empty_c),
    .byte_ready_c (tx_ready_c),
    .active_c     (tx_active_c),
    .tx           (tx)
  );

  assign busy = tx_active_c | ~fifo_empty_c | (req_cnt != '0);

endmodule

// File: tb/tb_rng_uart_stream.sv
// Scoreboard bench for rng_uart_stream: a bit-queue reference model predicts bytes,
// a UART frame monitor decodes tx and checks framing, parity and data in order.
module tb_rng_uart_stream;

  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned WORD_BYTES = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned BD         = 16;
  localparam int unsigned FRAME_LEN  = 11 * BD;
  localparam int unsigned SLOW_GAP   = 11;

  logic              sys_Clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] entropy_Bits = '0;
  logic              entropy_Valid = 1'b0;
  logic              button = 1'b0;
  logic              mode = 1'b1;
  logic              tx;
  logic              busy;
  logic              fifo_Overflow;

  rng_uart_stream #(
    .NUM_CH     (NUM_CH),
    .WORD_BYTES (WORD_BYTES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BD),
    .DEBIAS     (1'b1),
    .PARITY_EN  (1'b1)
  ) dut (
    .sys_Clk       (sys_Clk),
    .reset         (reset),
    .entropy_Bits  (entropy_Bits),
    .entropy_Valid (entropy_Valid),
    .button        (button),
    .mode          (mode),
    .tx            (tx),
    .busy          (busy),
    .fifo_Overflow (fifo_Overflow)
  );

  always #5 sys_Clk = ~sys_Clk;

  int total = 0;
  int bad = 0;
  int frames = 0;
  logic [7:0] exp_q[$];

  // Reference model state: pending raw bits, accepted bits, and the single-shot budget.
  bit raw_q[$];
  bit acc_q[$];
  bit model_cont = 1'b1;
  int want = 0;
  int produced = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_Clk);
    #1;
  endtask

  task automatic model_raw(input bit b);
    int v;
    raw_q.push_back(b);
    if (raw_q.size() == 2) begin
      if (raw_q[0] != raw_q[1]) acc_q.push_back(raw_q[0]);
      raw_q.delete();
    end
    if (acc_q.size() == 8) begin
      v = 0;
      for (int i = 0; i < 8; i++) v = v * 2 + int'(acc_q[i]);
      acc_q.delete();
      produced++;
      if (model_cont) begin
        exp_q.push_back(8'(v));
      end else if (want > 0) begin
        exp_q.push_back(8'(v));
        want--;
      end
    end
  endtask

  task automatic model_press();
    if (want == 0) begin
      raw_q.delete();
      acc_q.delete();
      want = WORD_BYTES;
    end
  endtask

  task automatic drive_raw(input bit b, input int gap);
    logic [NUM_CH-1:0] v;
    v = NUM_CH'($urandom);
    if ((^v) != b) v[0] = ~v[0];
    entropy_Bits  = v;
    entropy_Valid = 1'b1;
    tick();
    entropy_Valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic feed_random();
    bit b;
    b = 1'($urandom_range(0, 1));
    model_raw(b);
    drive_raw(b, SLOW_GAP);
  endtask

  // Each data bit, MSB first, becomes a 10 (one) or 01 (zero) pair.
  task automatic feed_byte_pairs(input logic [7:0] d, input int gap);
    for (int i = 7; i >= 0; i--) begin
      drive_raw(d[i], gap);
      drive_raw(~d[i], gap);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    repeat (3) tick();
    while (busy && n < 20000) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < 20000), 32'd1);
    repeat (3) tick();
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Frame monitor: records FRAME_LEN+1 samples from the first low sample, aborts on reset.
  logic samp [0:FRAME_LEN];
  bit   mon_active = 1'b0;
  int   mon_off = 0;

  task automatic eval_frame();
    logic [7:0] d;
    logic [7:0] e;
    logic       lvl;
    bit         shape_ok;
    shape_ok = 1'b1;
    for (int b = 0; b < 11; b++) begin
      lvl = samp[b * BD + BD / 2];
      for (int o = 0; o < int'(BD); o++) begin
        if (samp[b * BD + o] !== lvl) shape_ok = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) d[i] = samp[(i + 1) * BD + BD / 2];
    frames++;
    check("frame_shape", {28'd0, samp[BD / 2], samp[10 * BD + BD / 2], samp[FRAME_LEN], shape_ok},
          32'h7);
    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("frame_data", 32'(d), 32'(e));
      check("frame_parity", 32'(samp[9 * BD + BD / 2]), 32'(^e));
    end
  endtask

  always @(negedge sys_Clk) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_off = 0;
        samp[0] = tx;
      end
    end else begin
      mon_off++;
      samp[mon_off] = tx;
      if (mon_off == int'(FRAME_LEN)) begin
        mon_active = 1'b0;
        eval_frame();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         dir_raw [22];
    logic [7:0] ovf_bytes [6];
    int         f0;
    int         n;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(fifo_Overflow), 32'd0);
    reset = 1'b0;
    mode  = 1'b1;
    tick();

    // Directed debias sequence with discarded 00/11 pairs, then parity corner bytes
    dir_raw = '{0,1, 1,0, 0,0, 1,1, 1,0, 1,0, 0,1, 1,1, 0,1, 1,0, 1,0};
    exp_q.push_back(8'h73);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 22; i++) drive_raw(dir_raw[i], 2);
    feed_byte_pairs(8'hB2, 2);
    feed_byte_pairs(8'h01, 2);
    wait_drain("directed");
    check("directed_frames", 32'(frames), 32'd3);

    // Continuous random stream against the model
    model_cont = 1'b1;
    produced = 0;
    n = 0;
    while (produced < 8 && n < 4000) begin
      feed_random();
      n++;
    end
    check("cont_produced", 32'(produced), 32'd8);
    wait_drain("continuous");

    // Single-shot with an ignored second edge while the word is outstanding
    mode = 1'b0;
    model_cont = 1'b0;
    repeat (2) tick();
    f0 = frames;
    button = 1'b1;
    model_press();
    repeat (3) tick();
    check("ss_busy_pending", 32'(busy), 32'd1);
    button = 1'b0;
    repeat (3) tick();
    button = 1'b1;
    model_press();
    repeat (3) tick();
    n = 0;
    while (want > 0 && n < 4000) begin
      feed_random();
      n++;
    end
    repeat (40) feed_random();
    button = 1'b0;
    wait_drain("single_shot1");
    check("ss1_frames", 32'(frames - f0), WORD_BYTES);
    check("ss1_idle_tx", 32'(tx), 32'd1);

    // Second request after the first word completed
    f0 = frames;
    tick();
    button = 1'b1;
    model_press();
    tick();
    n = 0;
    while (want > 0 && n < 4000) begin
      feed_random();
      n++;
    end
    button = 1'b0;
    wait_drain("single_shot2");
    check("ss2_frames", 32'(frames - f0), WORD_BYTES);

    // Overflow: byte 1 goes to TX, bytes 2-5 fill the FIFO, byte 6 is dropped
    reset = 1'b1;
    mode  = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    f0 = frames;
    for (int i = 0; i < 6; i++) ovf_bytes[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) exp_q.push_back(ovf_bytes[i]);
    for (int i = 0; i < 5; i++) feed_byte_pairs(ovf_bytes[i], 0);
    repeat (2) tick();
    check("ovf_full_no_drop", 32'(fifo_Overflow), 32'd0);
    feed_byte_pairs(ovf_bytes[5], 0);
    repeat (2) tick();
    check("ovf_set", 32'(fifo_Overflow), 32'd1);
    wait_drain("overflow");
    check("ovf_frames", 32'(frames - f0), 32'd5);
    check("ovf_sticky", 32'(fifo_Overflow), 32'd1);

    // Reset in the middle of DATA with two more bytes queued
    f0 = frames;
    for (int i = 0; i < 3; i++) feed_byte_pairs(8'($urandom), 0);
    repeat (2 * BD) tick();
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(fifo_Overflow), 32'd0);
    reset = 1'b0;
    repeat (500) tick();
    check("mid_no_frames", 32'(frames - f0), 32'd0);
    check("mid_tx_idle", 32'(tx), 32'd1);
    check("mid_busy_idle", 32'(busy), 32'd0);

    // Fresh entropy after the abort produces a normal frame again
    f0 = frames;
    exp_q.push_back(8'h5A);
    feed_byte_pairs(8'h5A, 2);
    wait_drain("post_reset");
    check("post_reset_frames", 32'(frames - f0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
